fetch_sequencer: RTL and testbench

Instruction-fetch sequencer for the core. It owns the instruction pointer (irp) and the instruction register, and runs the fetch handshake to instruction memory. It also executes the flow-control ports written over the device bus: compare operands, conditional and direct jumps, wait and stop. It sits between the device-bus decode (which supplies an already-qualified enable) and the decoder, which consumes the instruction register.

---
 rtl/fetch_sequencer_if.sv | 23 ++
 rtl/fetch_sequencer.sv | 89 ++++++++
 tb/tb_fetch_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: device-bus port writes, instruction fetch handshake and IR hand-off
interface fetch_sequencer_if #(parameter int DATA_WIDTH = 16);
  logic                  i_dev_en;
  logic [3:0]            i_port;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_fetch_req;
  logic [DATA_WIDTH-1:0] o_fetch_addr;
  logic                  i_fetch_ack;
  logic [DATA_WIDTH-1:0] i_fetch_data;
  logic [DATA_WIDTH-1:0] o_ir;
  logic                  o_ir_valid;
  logic                  i_ir_ready;
  logic [DATA_WIDTH-1:0] o_irp;
  logic                  o_stopped;
  modport master (
    output i_dev_en, i_port, i_data, i_fetch_ack, i_fetch_data, i_ir_ready,
    input  o_fetch_req, o_fetch_addr, o_ir, o_ir_valid, o_irp, o_stopped
  );
  modport slave (
    input  i_dev_en, i_port, i_data, i_fetch_ack, i_fetch_data, i_ir_ready,
    output o_fetch_req, o_fetch_addr, o_ir, o_ir_valid, o_irp, o_stopped
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns irp/IR, runs the fetch handshake and executes bus-written flow control
module fetch_sequencer #(
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] RST_ADDR   = '0
) (
  input logic              clk,
  input logic              rst_n,
  fetch_sequencer_if.slave bus
);
  typedef enum logic [2:0] {S_RST, S_FETCH, S_HOLD, S_STALL, S_STOP} state_t;
  localparam logic [DATA_WIDTH-1:0] ONE = 1;
  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_irp, r_ir, r_cmp_a, r_cmp_b, r_target, r_wait_cnt;
  logic [DATA_WIDTH-1:0] w_irp_nxt, w_ir_nxt, w_wait_nxt;
  logic                  r_discard, r_stop_pending, w_discard_nxt, w_stop_pending_nxt;
  logic                  w_wr_wait, w_wr_stop, w_wr_direct, w_taken;
  assign w_wr_wait   = bus.i_dev_en && bus.i_port == 4'd8;
  assign w_wr_stop   = bus.i_dev_en && bus.i_port == 4'd9;
  assign w_wr_direct = bus.i_dev_en && bus.i_port == 4'd3;
  assign w_taken = w_wr_direct || (bus.i_dev_en && (
                   (bus.i_port == 4'd4 && r_cmp_a >  r_cmp_b) ||
                   (bus.i_port == 4'd5 && r_cmp_a <  r_cmp_b) ||
                   (bus.i_port == 4'd6 && r_cmp_a == r_cmp_b) ||
                   (bus.i_port == 4'd7 && r_cmp_a != r_cmp_b)));
  assign w_wait_nxt = w_wr_wait ? bus.i_data : (r_wait_cnt != '0) ? r_wait_cnt - ONE : r_wait_cnt;
  always_comb begin
    w_state_nxt        = r_state;
    w_irp_nxt          = w_taken ? r_target : r_irp;
    w_ir_nxt           = r_ir;
    w_discard_nxt      = r_discard;
    w_stop_pending_nxt = r_stop_pending;
    case (r_state)
      S_RST:   w_state_nxt = S_FETCH;
      S_FETCH: begin
        w_stop_pending_nxt = r_stop_pending || w_wr_stop;
        w_discard_nxt      = !bus.i_fetch_ack && (r_discard || w_taken);
        if (bus.i_fetch_ack && w_stop_pending_nxt)
          w_state_nxt = S_STOP;
        else if (bus.i_fetch_ack && !r_discard && !w_taken) begin
          w_ir_nxt    = bus.i_fetch_data;
          w_irp_nxt   = r_irp + ONE;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD:  w_state_nxt = w_wr_stop ? S_STOP :
                             (w_taken || bus.i_ir_ready) ? ((w_wait_nxt != '0) ? S_STALL : S_FETCH) : S_HOLD;
      S_STALL: w_state_nxt = w_wr_stop ? S_STOP : (r_wait_cnt == '0 && !w_wr_wait) ? S_FETCH : S_STALL;
      S_STOP: begin
        // only a direct jump restarts fetching; conditional jumps are absorbed here
        w_irp_nxt   = w_wr_direct ? r_target : r_irp;
        w_state_nxt = w_wr_direct ? S_FETCH : S_STOP;
      end
      default: w_state_nxt = S_RST;
    endcase
    if (w_state_nxt == S_STOP) begin
      w_discard_nxt      = 1'b0;
      w_stop_pending_nxt = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_RST;
      r_irp          <= RST_ADDR;
      r_ir           <= '0;
      r_cmp_a        <= '0;
      r_cmp_b        <= '0;
      r_target       <= '0;
      r_wait_cnt     <= '0;
      r_discard      <= 1'b0;
      r_stop_pending <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_irp          <= w_irp_nxt;
      r_ir           <= w_ir_nxt;
      r_wait_cnt     <= w_wait_nxt;
      r_discard      <= w_discard_nxt;
      r_stop_pending <= w_stop_pending_nxt;
      if (bus.i_dev_en && bus.i_port == 4'd0) r_cmp_a  <= bus.i_data;
      if (bus.i_dev_en && bus.i_port == 4'd1) r_cmp_b  <= bus.i_data;
      if (bus.i_dev_en && bus.i_port == 4'd2) r_target <= bus.i_data;
    end
  end
  assign bus.o_fetch_req  = r_state == S_FETCH;
  assign bus.o_fetch_addr = r_irp;
  assign bus.o_ir         = r_ir;
  assign bus.o_ir_valid   = r_state == S_HOLD;
  assign bus.o_irp        = r_irp;
  assign bus.o_stopped    = r_state == S_STOP;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed steps; fetched words go through a scoreboard queue to o_ir
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          tests = 0;
  int          fails = 0;
  logic [15:0] sb[$];
  fetch_sequencer_if #(.DATA_WIDTH(16)) bus();
  fetch_sequencer #(.DATA_WIDTH(16), .RST_ADDR(16'h0000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!bus.o_fetch_req && n < 20) begin
      step();
      n++;
    end
    check1({tag, "_req"}, bus.o_fetch_req, 1'b1);
  endtask
  task automatic fetch_one(input string tag, input logic [15:0] addr, input logic [15:0] data);
    wait_req(tag);
    check({tag, "_addr"}, bus.o_fetch_addr, addr);
    sb.push_back(data);
    bus.i_fetch_ack  = 1'b1;
    bus.i_fetch_data = data;
    step();
    bus.i_fetch_ack  = 1'b0;
    check1({tag, "_valid"}, bus.o_ir_valid, 1'b1);
    check({tag, "_ir"}, bus.o_ir, sb.pop_front());
    check({tag, "_irp"}, bus.o_irp, addr + 16'h1);
  endtask
  task automatic write_port(input logic [3:0] p, input logic [15:0] d);
    bus.i_dev_en = 1'b1;
    bus.i_port   = p;
    bus.i_data   = d;
    step();
    bus.i_dev_en = 1'b0;
  endtask
  task automatic consume();
    bus.i_ir_ready = 1'b1;
    step();
    bus.i_ir_ready = 1'b0;
  endtask
  initial begin
    int n;
    bus.i_dev_en = 1'b0; bus.i_port = '0; bus.i_data = '0;
    bus.i_fetch_ack = 1'b0; bus.i_fetch_data = '0; bus.i_ir_ready = 1'b0;
    repeat (3) step();
    check1("rst_req", bus.o_fetch_req, 1'b0);
    check1("rst_valid", bus.o_ir_valid, 1'b0);
    check1("rst_stopped", bus.o_stopped, 1'b0);
    check("rst_irp", bus.o_irp, 16'h0000);
    rst_n = 1'b1;
    step();
    check1("first_req", bus.o_fetch_req, 1'b1);
    // sequential fetch with the decoder always ready
    bus.i_ir_ready = 1'b1;
    for (int i = 0; i < 4; i++) fetch_one($sformatf("seq%0d", i), 16'(i), 16'h1000 + 16'(i));
    bus.i_ir_ready = 1'b0;
    check("seq_irp", bus.o_irp, 16'h0004);
    // compare-and-jump while holding an instruction
    write_port(4'd0, 16'd5);
    write_port(4'd1, 16'd3);
    write_port(4'd2, 16'h0040);
    check1("hold_kept", bus.o_ir_valid, 1'b1);
    write_port(4'd4, 16'h0);
    check1("jl_valid", bus.o_ir_valid, 1'b0);
    fetch_one("jl", 16'h0040, 16'hA040);
    write_port(4'd5, 16'h0);
    check1("js_valid", bus.o_ir_valid, 1'b1);
    check("js_irp", bus.o_irp, 16'h0041);
    consume();
    check("js_addr", bus.o_fetch_addr, 16'h0041);
    // taken jump with a request outstanding: late data must be dropped
    write_port(4'd2, 16'h0080);
    write_port(4'd3, 16'h0);
    check1("jd_req", bus.o_fetch_req, 1'b1);
    check("jd_addr", bus.o_fetch_addr, 16'h0080);
    repeat (2) step();
    bus.i_fetch_ack = 1'b1; bus.i_fetch_data = 16'hDEAD;
    step();
    bus.i_fetch_ack = 1'b0;
    check1("jd_drop_valid", bus.o_ir_valid, 1'b0);
    check1("jd_drop_req", bus.o_fetch_req, 1'b1);
    fetch_one("jd", 16'h0080, 16'hB080);
    // WAIT=4 then consume: four request-free cycles
    write_port(4'd8, 16'd4);
    consume();
    n = 0;
    while (!bus.o_fetch_req && n < 20) begin
      n++;
      step();
    end
    check("wait4_low", 16'(n), 16'd4);
    fetch_one("w4", 16'h0081, 16'hC081);
    write_port(4'd8, 16'd0);
    consume();
    check1("wait0_req", bus.o_fetch_req, 1'b1);
    // STOP with request outstanding
    write_port(4'd9, 16'h0);
    check1("stp_req1", bus.o_fetch_req, 1'b1);
    step();
    check1("stp_req2", bus.o_fetch_req, 1'b1);
    bus.i_fetch_ack = 1'b1; bus.i_fetch_data = 16'hBEEF;
    step();
    bus.i_fetch_ack = 1'b0;
    check1("stp_stopped", bus.o_stopped, 1'b1);
    check1("stp_req0", bus.o_fetch_req, 1'b0);
    check1("stp_valid", bus.o_ir_valid, 1'b0);
    write_port(4'd1, 16'd5);
    write_port(4'd6, 16'h0);
    check1("jeq_stopped", bus.o_stopped, 1'b1);
    check1("jeq_req", bus.o_fetch_req, 1'b0);
    write_port(4'd2, 16'h0010);
    write_port(4'd3, 16'h0);
    check1("restart_stopped", bus.o_stopped, 1'b0);
    fetch_one("restart", 16'h0010, 16'hD010);
    // irp wrap
    write_port(4'd2, 16'hFFFF);
    write_port(4'd3, 16'h0);
    fetch_one("wrap", 16'hFFFF, 16'hEFFF);
    consume();
    check("wrap_addr", bus.o_fetch_addr, 16'h0000);
    fetch_one("pre", 16'h0000, 16'h1111);
    consume();
    check("pre_addr", bus.o_fetch_addr, 16'h0001);
    // reset mid-fetch with a late ack
    rst_n = 1'b0;
    bus.i_fetch_ack = 1'b1; bus.i_fetch_data = 16'h5A5A;
    step();
    check1("mid_rst_req", bus.o_fetch_req, 1'b0);
    check("mid_rst_irp", bus.o_irp, 16'h0000);
    check("mid_rst_ir", bus.o_ir, 16'h0000);
    rst_n = 1'b1;
    step();
    bus.i_fetch_ack = 1'b0;
    check1("late_ack_valid", bus.o_ir_valid, 1'b0);
    check("late_ack_irp", bus.o_irp, 16'h0000);
    fetch_one("post", 16'h0000, 16'h2222);
    check("sb_empty", 16'(sb.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
